ram_data_arbiter: RTL and testbench

//  Shares the single data port (port B) of the dual-port RAM between two requesters:
//  M0 = core load/store unit, M1 = DMA/program loader. Per-cycle arbitration with a
//  req/gnt handshake; read data is routed back to the issuing master after the RAM's

---
 rtl/ram_data_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_data_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_data_arbiter.sv
// Two-master arbiter for the shared RAM data port (M0 = LSU, M1 = DMA/loader).
// Per-cycle req/gnt arbitration, registered read-response routing by issue id.
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_mN_req/addr/wr_data/      master N request fields (N = 0,1),
//     size/we                   held stable until granted
//   o_mN_gnt                    combinational grant, one master per cycle
//   o_mN_rvalid, o_mN_rd_data   read response for master N
//   o_ram_addr/wr_data/size/we  muxed request toward the RAM data port
//   i_ram_rd_data               RAM read data, RD_LATENCY cycles after accept
module ram_data_arbiter #(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 8,
    parameter int RD_LATENCY   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wr_data,
    input  logic [1:0]  i_m0_size,
    input  logic        i_m0_we,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rd_data,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wr_data,
    input  logic [1:0]  i_m1_size,
    input  logic        i_m1_we,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rd_data,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_wr_data,
    output logic [1:0]  o_ram_size,
    output logic        o_ram_we,
    input  logic [31:0] i_ram_rd_data
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    localparam int         LAST  = RD_LATENCY - 1;

    // last_gnt: 0 = M0, 1 = M1
    logic                  last_q, last_d;
    logic [7:0]            starve_q, starve_d;
    logic [RD_LATENCY-1:0] pv_q, pv_d;
    logic [RD_LATENCY-1:0] pid_q, pid_d;
    logic                  g0, g1;
    logic                  rd_acc;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (i_rst_n) begin
            if (i_m0_req && i_m1_req) begin
                if (ARB_MODE == 0) begin
                    // Grant the master that did not win last time.
                    g0 = last_q;
                    g1 = !last_q;
                end else begin
                    // M0 has priority unless M1 has waited long enough.
                    g1 = (starve_q == LIMIT);
                    g0 = !g1;
                end
            end else begin
                g0 = i_m0_req;
                g1 = i_m1_req;
            end
        end
    end

    assign rd_acc = (g0 && !i_m0_we) || (g1 && !i_m1_we);

    always_comb begin
        last_d = last_q;
        if (g1) begin
            last_d = 1'b1;
        end else if (g0) begin
            last_d = 1'b0;
        end

        starve_d = starve_q;
        if (!i_m1_req || g1) begin
            starve_d = 8'd0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 8'd1;
        end

        pv_d     = pv_q;
        pid_d    = pid_q;
        pv_d[0]  = rd_acc;
        pid_d[0] = g1;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_q   <= 1'b1;
            starve_q <= 8'd0;
            pv_q     <= '0;
            pid_q    <= '0;
        end else begin
            last_q   <= last_d;
            starve_q <= starve_d;
            pv_q     <= pv_d;
            pid_q    <= pid_d;
        end
    end

    assign o_m0_gnt = g0;
    assign o_m1_gnt = g1;

    // Idle cycles present M0's fields with the write strobe low.
    assign o_ram_addr    = g1 ? i_m1_addr    : i_m0_addr;
    assign o_ram_wr_data = g1 ? i_m1_wr_data : i_m0_wr_data;
    assign o_ram_size    = g1 ? i_m1_size    : i_m0_size;
    assign o_ram_we      = (g0 && i_m0_we) || (g1 && i_m1_we);

    // Gated by reset so in-flight reads never surface during reset.
    assign o_m0_rvalid  = i_rst_n && pv_q[LAST] && !pid_q[LAST];
    assign o_m1_rvalid  = i_rst_n && pv_q[LAST] && pid_q[LAST];
    assign o_m0_rd_data = i_ram_rd_data;
    assign o_m1_rd_data = i_ram_rd_data;

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Bench for ram_data_arbiter: three instances (RR/lat1, PRIO limit3/lat1,
// RR/lat2) share one stimulus; read responses are checked via a scoreboard.
module tb_ram_data_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic [1:0]  m0_size, m1_size;

    logic [2:0]  gnt0, gnt1, rv0, rv1, rwe;
    logic [31:0] rd0 [3];
    logic [31:0] rd1 [3];
    logic [31:0] raddr [3];
    logic [31:0] rwd [3];
    logic [1:0]  rsize [3];
    logic [31:0] rram [3];

    logic [31:0] wmem [3][64];
    bit          wv [3][64];
    logic [31:0] s1 [3];
    logic [31:0] s2;

    exp_t        sbq [3][$];
    int          cyc;
    int          checks;
    int          failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    ram_data_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(8), .RD_LATENCY(1)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wr_data(m0_wd),
        .i_m0_size(m0_size), .i_m0_we(m0_we),
        .o_m0_gnt(gnt0[0]), .o_m0_rvalid(rv0[0]), .o_m0_rd_data(rd0[0]),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wr_data(m1_wd),
        .i_m1_size(m1_size), .i_m1_we(m1_we),
        .o_m1_gnt(gnt1[0]), .o_m1_rvalid(rv1[0]), .o_m1_rd_data(rd1[0]),
        .o_ram_addr(raddr[0]), .o_ram_wr_data(rwd[0]),
        .o_ram_size(rsize[0]), .o_ram_we(rwe[0]), .i_ram_rd_data(rram[0])
    );

    ram_data_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(3), .RD_LATENCY(1)) u_pr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wr_data(m0_wd),
        .i_m0_size(m0_size), .i_m0_we(m0_we),
        .o_m0_gnt(gnt0[1]), .o_m0_rvalid(rv0[1]), .o_m0_rd_data(rd0[1]),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wr_data(m1_wd),
        .i_m1_size(m1_size), .i_m1_we(m1_we),
        .o_m1_gnt(gnt1[1]), .o_m1_rvalid(rv1[1]), .o_m1_rd_data(rd1[1]),
        .o_ram_addr(raddr[1]), .o_ram_wr_data(rwd[1]),
        .o_ram_size(rsize[1]), .o_ram_we(rwe[1]), .i_ram_rd_data(rram[1])
    );

    ram_data_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(8), .RD_LATENCY(2)) u_l2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wr_data(m0_wd),
        .i_m0_size(m0_size), .i_m0_we(m0_we),
        .o_m0_gnt(gnt0[2]), .o_m0_rvalid(rv0[2]), .o_m0_rd_data(rd0[2]),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wr_data(m1_wd),
        .i_m1_size(m1_size), .i_m1_we(m1_we),
        .o_m1_gnt(gnt1[2]), .o_m1_rvalid(rv1[2]), .o_m1_rd_data(rd1[2]),
        .o_ram_addr(raddr[2]), .o_ram_wr_data(rwd[2]),
        .o_ram_size(rsize[2]), .o_ram_we(rwe[2]), .i_ram_rd_data(rram[2])
    );

    function automatic logic [31:0] ram_val(input int d, input logic [31:0] a);
        if (wv[d][a[7:2]]) return wmem[d][a[7:2]];
        if (a == 32'h40) return 32'hDEADBEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    // RAM models: one registered read stage, plus a second one for latency 2.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rwe[d] === 1'b1) begin
                wmem[d][raddr[d][7:2]] <= rwd[d];
                wv[d][raddr[d][7:2]]   <= 1'b1;
            end
            s1[d] <= ram_val(d, raddr[d]);
        end
        s2 <= s1[2];
    end

    assign rram[0] = s1[0];
    assign rram[1] = s1[1];
    assign rram[2] = s2;

    task automatic chk(input string tag, input int d,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s dut%0d cyc=%0d got=%h exp=%h", tag, d, cyc, got, exp);
        end
    endtask

    task automatic check_resp();
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                chk("rvalid0_rst", d, 32'(rv0[d]), 32'd0);
                chk("rvalid1_rst", d, 32'(rv1[d]), 32'd0);
                sbq[d].delete();
            end else if (sbq[d].size() > 0 && sbq[d][0].due == cyc) begin
                e = sbq[d].pop_front();
                chk("rvalid0", d, 32'(rv0[d]), 32'(!e.id));
                chk("rvalid1", d, 32'(rv1[d]), 32'(e.id));
                if (e.id) chk("rdata1", d, rd1[d], e.data);
                else      chk("rdata0", d, rd0[d], e.data);
            end else begin
                chk("rvalid0_idle", d, 32'(rv0[d]), 32'd0);
                chk("rvalid1_idle", d, 32'(rv1[d]), 32'd0);
            end
        end
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic w0,
                         input logic r1, input logic [31:0] a1, input logic w1);
        m0_req  = r0;
        m0_addr = a0;
        m0_we   = w0;
        m1_req  = r1;
        m1_addr = a1;
        m1_we   = w1;
    endtask

    task automatic cycle(input logic [2:0] e0, input logic [2:0] e1);
        exp_t e;
        int   lat;
        #1;
        check_resp();
        for (int d = 0; d < 3; d++) begin
            lat = (d == 2) ? 2 : 1;
            chk("gnt0", d, 32'(gnt0[d]), 32'(e0[d]));
            chk("gnt1", d, 32'(gnt1[d]), 32'(e1[d]));
            chk("ram_we", d, 32'(rwe[d]),
                32'((e0[d] && m0_we) || (e1[d] && m1_we)));
            chk("ram_addr", d, raddr[d], e1[d] ? m1_addr : m0_addr);
            chk("ram_size", d, 32'(rsize[d]), 32'(e1[d] ? m1_size : m0_size));
            if (e0[d] && m0_we) chk("ram_wdata", d, rwd[d], m0_wd);
            if (e0[d] && !m0_we) begin
                e = '{id: 1'b0, data: ram_val(d, m0_addr), due: cyc + lat};
                sbq[d].push_back(e);
            end
            if (e1[d] && !m1_we) begin
                e = '{id: 1'b1, data: ram_val(d, m1_addr), due: cyc + lat};
                sbq[d].push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            cycle(3'b000, 3'b000);
        end
    endtask

    // Bit d = instance d; M0 grant pattern under continuous contention.
    logic [2:0] pat [8] = '{3'b111, 3'b010, 3'b111, 3'b000,
                            3'b111, 3'b010, 3'b111, 3'b000};

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        m0_wd    = 32'hCAFEF00D;
        m1_wd    = 32'h5555AAAA;
        m0_size  = 2'd2;
        m1_size  = 2'd1;
        rst_n    = 1'b0;
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b0);
        @(posedge clk);
        #1;

        // Reset holds off grants even with both requesting.
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);
        rst_n = 1'b1;

        // Continuous contention: RR alternates, PRIO forces M1 every 4th.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0,
                  1'b1, 32'h200 + 32'(4 * i), 1'b0);
            cycle(pat[i], ~pat[i]);
        end
        idle(2);

        // M1 read routing, then M0 write with no response.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
        cycle(3'b000, 3'b111);
        drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(3'b111, 3'b000);
        idle(2);
        drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(3'b111, 3'b000);
        idle(2);

        // Back-to-back alternating single-master reads.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                drive(1'b1, 32'h10 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0);
                cycle(3'b111, 3'b000);
            end else begin
                drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h10 + 32'(4 * i), 1'b0);
                cycle(3'b000, 3'b111);
            end
        end
        idle(3);

        // Reset right after a read is accepted discards its response.
        drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(3'b111, 3'b000);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // After reset M0 wins the first contention again.
        drive(1'b1, 32'h30, 1'b0, 1'b1, 32'h34, 1'b0);
        cycle(3'b111, 3'b000);
        idle(3);

        for (int d = 0; d < 3; d++) begin
            chk("sb_empty", d, 32'(sbq[d].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
